// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

   localparam int unsigned ADDR_W          = 32;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned TIMEOUT_CYC_DEF = 64;
   localparam int unsigned CNT_W_DEF       = 16;

   // Load data returned when an access is aborted by the timeout
   localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable, synchronous clear and async active-low reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   // Count enabled cycles, holding at all ones
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (en_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences EX/MEM loads/stores over a req/ack data-memory handshake and
// stalls the pipeline until each access completes or times out.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              Memoryread_i,
   input  logic              Memorywrite_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t          state;
   logic            op;
   logic            to_en;
   logic            to_clr;
   logic            to_hit;
   logic [TO_W-1:0] to_cnt;

   assign op = Memoryread_i | Memorywrite_i;

   // Freeze the front of the pipeline from op detection until DONE
   assign stall_o = (op && (state != DONE)) || (state == REQ);

   // Timeout counts REQ cycles without ack; cleared on the way out via DONE
   assign to_en  = (state == REQ) && !mem_ack_i;
   assign to_clr = (state == DONE);
   assign to_hit = (to_cnt == TO_LAST);

   sat_counter #(.W(TO_W)) u_to_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (to_clr),
      .en_i  (to_en),
      .cnt_o (to_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .en_i  (stall_o),
      .cnt_o (stall_cnt_o)
   );

   // Access FSM with registered memory-side outputs, load data and error flag
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op) begin
                  mem_addr_o  <= addr_i;
                  mem_wdata_o <= wdata_i;
                  mem_we_o    <= Memorywrite_i;
                  mem_req_o   <= 1'b1;
                  state       <= REQ;
                  // Read+write together is illegal; it proceeds as a write
                  if (Memoryread_i && Memorywrite_i) begin
                     err_o <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  state     <= DONE;
                  if (!mem_we_o) begin
                     rdata_o <= mem_rdata_i;
                  end
               end else if (to_hit) begin
                  mem_req_o <= 1'b0;
                  err_o     <= 1'b1;
                  rdata_o   <= ERR_RDATA;
                  state     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, corner
// sequences and randomized traffic against a transaction-level model.
module tb_dmem_access_ctrl;

   localparam int unsigned TO      = 8;
   localparam int unsigned CNT_MAX = 65535;
   localparam int unsigned SAT_MAX = 15;

   logic        clk;
   logic        rst_i;
   logic        Memoryread_i;
   logic        Memorywrite_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   logic        mem_req_o, mem_we_o, stall_o, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
   logic [15:0] stall_cnt_o;

   logic        s_req, s_we, s_stall, s_err;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_cnt;

   dmem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .Memoryread_i(Memoryread_i), .Memorywrite_i(Memorywrite_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
      .stall_cnt_o(stall_cnt_o)
   );

   // Narrow counter copy so saturation is reached quickly
   dmem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut_sat (
      .clk_i(clk), .rst_i(rst_i),
      .Memoryread_i(Memoryread_i), .Memorywrite_i(Memorywrite_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
      .mem_req_o(s_req), .mem_we_o(s_we),
      .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .rdata_o(s_rdata), .stall_o(s_stall), .err_o(s_err),
      .stall_cnt_o(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_total;
   int unsigned n_pass;

   // Transaction-level model: is an access outstanding, how long has it waited
   bit          m_busy;
   bit          m_finishing;
   int unsigned m_waited;
   bit          m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;
   bit          m_err;
   int unsigned m_stalls;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   function automatic bit model_stall();
      return ((Memoryread_i || Memorywrite_i) && !m_finishing) || m_busy;
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_clear();
      m_busy = 0; m_finishing = 0; m_waited = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0; m_stalls = 0;
   endtask

   task automatic check_model();
      chk("stall",     64'(stall_o),     64'(model_stall()));
      chk("mem_req",   64'(mem_req_o),   64'(m_busy));
      chk("mem_we",    64'(mem_we_o),    64'(m_we));
      chk("mem_addr",  64'(mem_addr_o),  64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
      chk("rdata",     64'(rdata_o),     64'(m_rdata));
      chk("err",       64'(err_o),       64'(m_err));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(sat(m_stalls, CNT_MAX)));
      chk("sat_cnt",   64'(s_cnt),       64'(sat(m_stalls, SAT_MAX)));
      chk("sat_ctl",   64'({s_req, s_we, s_stall, s_err}),
                       64'({m_busy, m_we, model_stall(), m_err}));
      chk("sat_data",  64'({s_addr, s_wdata ^ s_rdata}), 64'({m_addr, m_wdata ^ m_rdata}));
   endtask

   // Advance the model across one rising edge given the inputs now applied
   task automatic model_step();
      if (model_stall()) m_stalls++;
      if (m_finishing) begin
         m_finishing = 0;
         m_waited    = 0;
      end else if (m_busy) begin
         if (mem_ack_i) begin
            m_busy = 0; m_finishing = 1;
            if (!m_we) m_rdata = mem_rdata_i;
         end else if (m_waited + 1 == TO) begin
            m_busy = 0; m_finishing = 1; m_err = 1; m_rdata = '0;
         end else begin
            m_waited++;
         end
      end else if (Memoryread_i || Memorywrite_i) begin
         m_busy = 1; m_waited = 0;
         m_we = Memorywrite_i; m_addr = addr_i; m_wdata = wdata_i;
         if (Memoryread_i && Memorywrite_i) m_err = 1;
      end
   endtask

   task automatic cycle(input logic rd, input logic wr, input logic ack,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt);
      @(negedge clk);
      Memoryread_i = rd; Memorywrite_i = wr; mem_ack_i = ack;
      addr_i = a; wdata_i = wd; mem_rdata_i = rdt;
      #1;
      check_model();
      model_step();
   endtask

   // Asynchronous reset landing mid-cycle; pipeline op lines drop with it
   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_i = 1'b0; Memoryread_i = 0; Memorywrite_i = 0; mem_ack_i = 0;
      #1;
      model_clear();
      chk("rst_req",   64'(mem_req_o),   64'(0));
      chk("rst_stall", 64'(stall_o),     64'(0));
      chk("rst_outs",  64'({mem_we_o, err_o, stall_cnt_o}), 64'(0));
      chk("rst_data",  64'(mem_addr_o | mem_wdata_o | rdata_o), 64'(0));
      @(negedge clk);
      rst_i = 1'b1;
   endtask

   typedef struct {
      logic        rd, wr, ack;
      logic [31:0] addr, wdata, mrdata;
      logic        e_stall, e_req, e_we;
      logic [31:0] e_rdata;
      logic        e_err;
      int unsigned e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic rd, input logic wr, input logic ack,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt,
                               input logic es, input logic eq, input logic ew,
                               input logic [31:0] erd, input logic ee, input int unsigned ec);
      vec_t v;
      v.rd = rd; v.wr = wr; v.ack = ack; v.addr = a; v.wdata = wd; v.mrdata = rdt;
      v.e_stall = es; v.e_req = eq; v.e_we = ew; v.e_rdata = erd; v.e_err = ee; v.e_cnt = ec;
      return v;
   endfunction

   vec_t tbl[19];
   int   req_hi;

   initial begin
      n_total = 0; n_pass = 0;
      rst_i = 1'b0; Memoryread_i = 0; Memorywrite_i = 0; mem_ack_i = 0;
      addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
      model_clear();

      //            rd wr ack addr   wdata         mrdata        stl req we rdata         err cnt
      tbl[0]  = mk(1, 0, 0, 32'h100, 32'h0,        32'h0,        1, 0, 0, 32'h0,        0, 0);
      tbl[1]  = mk(1, 0, 1, 32'h100, 32'h0,        32'h12345678, 1, 1, 0, 32'h0,        0, 1);
      tbl[2]  = mk(1, 0, 0, 32'h100, 32'h0,        32'h0,        0, 0, 0, 32'h12345678, 0, 2);
      tbl[3]  = mk(0, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 32'h12345678, 0, 2);
      tbl[4]  = mk(0, 1, 0, 32'h20,  32'hCAFEF00D, 32'h0,        1, 0, 0, 32'h12345678, 0, 2);
      tbl[5]  = mk(0, 1, 0, 32'h20,  32'hCAFEF00D, 32'hFFFF0000, 1, 1, 1, 32'h12345678, 0, 3);
      tbl[6]  = mk(0, 1, 0, 32'h20,  32'hCAFEF00D, 32'h0,        1, 1, 1, 32'h12345678, 0, 4);
      tbl[7]  = mk(0, 1, 0, 32'h20,  32'hCAFEF00D, 32'h0,        1, 1, 1, 32'h12345678, 0, 5);
      tbl[8]  = mk(0, 1, 1, 32'h20,  32'hCAFEF00D, 32'hBADBAD00, 1, 1, 1, 32'h12345678, 0, 6);
      tbl[9]  = mk(0, 1, 0, 32'h20,  32'hCAFEF00D, 32'h0,        0, 0, 1, 32'h12345678, 0, 7);
      tbl[10] = mk(0, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 1, 32'h12345678, 0, 7);
      tbl[11] = mk(1, 0, 0, 32'h40,  32'h0,        32'h0,        1, 0, 1, 32'h12345678, 0, 7);
      tbl[12] = mk(1, 0, 1, 32'h40,  32'h0,        32'hA5A5A5A5, 1, 1, 0, 32'h12345678, 0, 8);
      tbl[13] = mk(1, 0, 0, 32'h40,  32'h0,        32'h0,        0, 0, 0, 32'hA5A5A5A5, 0, 9);
      tbl[14] = mk(0, 1, 0, 32'h44,  32'h11112222, 32'h0,        1, 0, 0, 32'hA5A5A5A5, 0, 9);
      tbl[15] = mk(0, 1, 1, 32'h44,  32'h11112222, 32'h0,        1, 1, 1, 32'hA5A5A5A5, 0, 10);
      tbl[16] = mk(0, 1, 0, 32'h44,  32'h11112222, 32'h0,        0, 0, 1, 32'hA5A5A5A5, 0, 11);
      tbl[17] = mk(0, 0, 1, 32'h0,   32'h0,        32'h55555555, 0, 0, 1, 32'hA5A5A5A5, 0, 11);
      tbl[18] = mk(0, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 1, 32'hA5A5A5A5, 0, 11);

      repeat (2) @(negedge clk);
      #1;
      chk("reset_outs", 64'({mem_req_o, mem_we_o, stall_o, err_o, stall_cnt_o}), 64'(0));
      chk("reset_data", 64'(mem_addr_o | mem_wdata_o | rdata_o), 64'(0));
      @(negedge clk);
      rst_i = 1'b1;

      // Directed load / slow store / back-to-back / stray ack
      for (int i = 0; i < 19; i++) begin
         cycle(tbl[i].rd, tbl[i].wr, tbl[i].ack, tbl[i].addr, tbl[i].wdata, tbl[i].mrdata);
         chk($sformatf("vec%0d_stall", i), 64'(stall_o),     64'(tbl[i].e_stall));
         chk($sformatf("vec%0d_req", i),   64'(mem_req_o),   64'(tbl[i].e_req));
         chk($sformatf("vec%0d_we", i),    64'(mem_we_o),    64'(tbl[i].e_we));
         chk($sformatf("vec%0d_rdata", i), 64'(rdata_o),     64'(tbl[i].e_rdata));
         chk($sformatf("vec%0d_err", i),   64'(err_o),       64'(tbl[i].e_err));
         chk($sformatf("vec%0d_cnt", i),   64'(stall_cnt_o), 64'(tbl[i].e_cnt));
         if (i >= 5 && i <= 8)
            chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata_o), 64'(32'hCAFEF00D));
         if (i == 1)
            chk("vec1_addr", 64'(mem_addr_o), 64'(32'h100));
      end

      // Timeout: load never acknowledged
      cycle(1, 0, 0, 32'h300, 32'h0, 32'h0);
      req_hi = 0;
      for (int i = 0; i < 9; i++) begin
         cycle(1, 0, 0, 32'h300, 32'h0, 32'h0);
         if (mem_req_o) req_hi++;
      end
      chk("to_req_cycles", 64'(req_hi),  64'(8));
      chk("to_err",        64'(err_o),   64'(1));
      chk("to_rdata",      64'(rdata_o), 64'(0));
      chk("to_stall_rel",  64'(stall_o), 64'(0));
      cycle(0, 1, 0, 32'h304, 32'h9, 32'h0);
      cycle(0, 1, 1, 32'h304, 32'h9, 32'h0);
      cycle(0, 1, 0, 32'h304, 32'h9, 32'h0);
      chk("to_err_sticky", 64'(err_o), 64'(1));

      // Reset in the middle of a store, then a late ack
      async_reset();
      cycle(0, 1, 0, 32'h500, 32'hDEADBEEF, 32'h0);
      cycle(0, 1, 0, 32'h500, 32'hDEADBEEF, 32'h0);
      async_reset();
      cycle(0, 0, 1, 32'h0, 32'h0, 32'h87654321);
      cycle(0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("late_ack_quiet", 64'({mem_req_o, err_o, stall_o}), 64'(0));
      chk("late_ack_rdata", 64'(rdata_o), 64'(0));

      // Illegal read+write proceeds as a write and flags an error
      cycle(1, 1, 0, 32'h600, 32'h77, 32'h0);
      cycle(1, 1, 0, 32'h600, 32'h77, 32'h0);
      chk("ill_we",  64'(mem_we_o), 64'(1));
      chk("ill_err", 64'(err_o),    64'(1));
      cycle(1, 1, 1, 32'h600, 32'h77, 32'h0);
      cycle(1, 1, 0, 32'h600, 32'h77, 32'h0);
      cycle(0, 0, 1, 32'h0, 32'h0, 32'h33);
      cycle(0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("ill_stray_ack", 64'({mem_req_o, stall_o, err_o}), 64'(1));

      // Randomized traffic against the model
      async_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
         end else begin
            cycle(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 3)  ? 1'b1 : 1'b0,
                  $urandom, $urandom, $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access requested by the EX/MEM pipeline register outputs (Memoryread/Memorywrite, ALU result as address, forwarded rs2 as store data).
- Drives a request/acknowledge handshake to a variable-latency data memory.
- Asserts a global pipeline stall until the access completes, then presents load data to the MEM/WB register.
- Sits between EX/MEM, the data memory and the hazard/stall logic.

Parameters:
- TIMEOUT_CYC, 64, REQ cycles without mem_ack_i before the access is aborted.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- Memoryread_i  in  1  load requested by EX/MEM
- Memorywrite_i  in  1  store requested by EX/MEM
- addr_i  in  32  byte address (EX/MEM ALU result)
- wdata_i  in  32  store data (EX/MEM forwarded rs2)
- mem_req_o  out  1  request to data memory
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_ack_i  in  1  memory completion, 1-cycle pulse
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- rdata_o  out  32  load data to MEM/WB
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- err_o  out  1  sticky error flag
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset (rst_i = 0, any time including mid-access):
  - state = IDLE.
  - mem_req_o, mem_we_o, err_o = 0.
  - mem_addr_o, mem_wdata_o, rdata_o = 0.
  - stall_cnt_o = 0; timeout counter = 0.
  - The in-flight access is abandoned; a late mem_ack_i after reset is ignored.
- op = Memoryread_i | Memorywrite_i.
- stall_o is combinational:
  - stall_o = op & (state != DONE), or state == REQ.
  - stall_o is 0 in DONE, so the pipeline advances on the edge that leaves DONE.
- IDLE:
  - If op: at the edge, latch addr_i, wdata_i and we = Memorywrite_i into mem_addr_o, mem_wdata_o and mem_we_o. Set mem_req_o = 1 and go to REQ.
  - Otherwise stay in IDLE with mem_req_o = 0.
- REQ:
  - mem_req_o stays 1; address, data and we are held stable.
  - On mem_ack_i: mem_req_o = 0 and go to DONE.
    - Read: rdata_o <= mem_rdata_i.
    - Write: rdata_o is unchanged.
  - Otherwise increment the timeout counter. At count TIMEOUT_CYC-1 with no ack:
    - mem_req_o = 0, err_o = 1, rdata_o = 0, go to DONE.
    - An ack arriving on that same cycle takes priority; it is a normal completion with no error.
- DONE:
  - Unconditionally return to IDLE; clear the timeout counter.
  - The EX/MEM contents change at this edge, so a back-to-back memory op is seen fresh in IDLE.
- Latency:
  - Minimum 3 cycles per access (IDLE-detect, REQ with ack, DONE), i.e. 2 stalled cycles.
  - Each additional cycle of memory latency adds one stall cycle.
- Read and write both set: treated as a write; err_o = 1 at the IDLE edge.
- mem_ack_i in IDLE or DONE: ignored; err_o unaffected.
- err_o is cleared only by reset.
- stall_cnt_o increments every cycle stall_o = 1 and saturates at all ones.
- rdata_o holds its value until the next completed read.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2);
  - ERR_RDATA = 32'h0 constant;
  - default TIMEOUT_CYC.
- One natural sub-module, sat_counter (parameterised width, enable, async active-low clear). It is used for stall_cnt_o and is reusable for the timeout counter.

Test Plan:
- Load, ack after 1 REQ cycle: Memoryread_i = 1, addr_i = 0x100, mem_rdata_i = 0x12345678.
  - Required: mem_req_o high 1 cycle with mem_we_o = 0 and mem_addr_o = 0x100.
  - Required: stall_o high exactly 2 cycles; rdata_o = 0x12345678 in DONE; stall_cnt_o = 2.
- Store, ack after 4 REQ cycles: Memorywrite_i = 1, addr_i = 0x20, wdata_i = 0xCAFEF00D.
  - Required: mem_we_o = 1 and mem_wdata_o held at 0xCAFEF00D for all 4 cycles.
  - Required: stall_o high 5 cycles; rdata_o unchanged.
- Back-to-back: load then store in consecutive EX/MEM contents, 1-cycle acks.
  - Required: two separate request windows separated by DONE→IDLE; stall_cnt_o = 4; no err_o.
- Timeout: TIMEOUT_CYC = 8, load, never ack.
  - Required: mem_req_o drops after 8 REQ cycles; err_o = 1; rdata_o = 0; stall_o releases in DONE.
  - Required: err_o stays 1 through a later good access.
- Reset mid-REQ: assert rst_i low during REQ of a store.
  - Required: immediate mem_req_o = 0, stall_o = 0, all outputs 0.
  - Required: a mem_ack_i pulse after reset release has no effect.
- Illegal op: Memoryread_i = Memorywrite_i = 1.
  - Required: a write access is issued (mem_we_o = 1) and err_o = 1 from the next cycle.
  - Required: a stray mem_ack_i in IDLE is ignored.
